wdt_kick_gate: RTL and testbench
================================

# wdt_kick_gate

Upstream qualifier for the watchdog. Converts a raw strobe/byte pair from the pins into a single-cycle `kick` pulse. A kick is issued only after the two-byte unlock sequence KEY0 then KEY1 arrives within a bounded gap and, optionally, no earlier than a minimum period after the previous kick. Malformed, timed-out and early sequences raise error pulses instead, and the watchdog consumes those as well.

## Interface
- `KEY0`, 8'h55: first unlock byte.
- `KEY1`, 8'hAA: second unlock byte.
- `GAP_MAX`, 16: maximum cycles allowed in ARMED while waiting for KEY1; range 1..255.
- `MIN_PERIOD`, 8: minimum cycles between accepted kicks (window mode only); range 1..255.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  block enable, synchronous to `clk`.
- `key_strobe`  in  1  asynchronous strobe from a pin; its rising edge qualifies `key_in`.
- `key_in`  in  8  key byte; must be stable from the strobe rising edge until 4 cycles later.
- `kick`  out  1  single-cycle kick pulse to the watchdog.
- `early_err`  out  1  single-cycle pulse: valid sequence completed inside the minimum window.
- `bad_key_err`  out  1  single-cycle pulse: wrong byte, or gap timeout in ARMED.
- `armed`  out  1  high while the FSM is in ARMED.
- `kick_count`  out  8  accepted kicks, saturating at 8'hFF.

## Operation
- Strobe path:
  - 2-flop synchronizer, then a third flop `prev`.
  - Event `ev = sync2 & ~prev`.
  - `key_in` is sampled unsynchronized in the cycle `ev` is high.
- FSM states: IDLE, ARMED. Reset state is IDLE.
- IDLE:
  - `ev` with KEY0 goes to ARMED and clears `gap_cnt`.
  - `ev` with any other byte pulses `bad_key_err` and stays in IDLE.
- ARMED:
  - `gap_cnt` increments every cycle without `ev`.
  - `ev` with KEY1 completes the sequence and returns to IDLE.
  - `ev` with KEY0 stays in ARMED and clears `gap_cnt` (re-arm, no error).
  - `ev` with any other byte pulses `bad_key_err` and returns to IDLE.
  - If `gap_cnt` reaches GAP_MAX with no `ev`, pulse `bad_key_err` and return to IDLE.
- Sequence completion:
  - If `since_kick >= MIN_PERIOD` (or window mode is compiled out), pulse `kick`, increment `kick_count` (saturating), and clear `since_kick`.
  - Otherwise pulse `early_err`; `since_kick` is unchanged.
- `since_kick` increments every enabled cycle and saturates at MIN_PERIOD. Its reset value is MIN_PERIOD, so the first kick after reset is always accepted.
- `ena` low:
  - FSM forced to IDLE.
  - `ev` ignored; no pulses.
  - `since_kick` and `kick_count` hold.
  - The synchronizer keeps running, so no stale edge fires when `ena` rises.
- Reset values: all outputs 0, synchronizer flops 0, `gap_cnt` 0.
- Reset asserted mid-sequence aborts it with no pulse.

## Timing
- `key_strobe` first sampled high at edge E0: `sync2` high after E1, `ev` high in the cycle after E1, FSM updates and `kick`/error registered at E2.
- Result: outputs are high for exactly one cycle after E2, so kick latency is 2 cycles from the first sampling edge.
- All outputs are registered. `kick`, `early_err` and `bad_key_err` are mutually exclusive and never high for two consecutive cycles from one event.
- Minimum strobe spacing: strobe low for at least 2 cycles between bytes. A strobe held high yields one event.
- Simultaneous `ev` and gap timeout in ARMED: `ev` wins; the timeout is discarded.
- `armed` reflects the FSM register, with no combinational path from inputs.

## Configuration
- `WDT_KICK_WINDOW_EN`
  - Defined: `since_kick` counter and early-window check are present, as described above.
  - Undefined: the counter is removed, every completed sequence kicks, and `early_err` is tied to 0.

## Structure
- Package `wdt_pkg` holds:
  - the FSM state typedef (`wdt_kick_state_e`: IDLE, ARMED);
  - default key constants `WDT_KEY0`, `WDT_KEY1`;
  - default GAP_MAX and MIN_PERIOD localparams.
- One sub-module, `wdt_sync_edge`: 2-flop synchronizer plus rising-edge detector with async active-high reset. It is reusable for other pin inputs.

## Test plan
- Reset, then bytes 8'h55, 8'hAA (strobes 4 cycles apart) -> one `kick` 2 cycles after the second strobe's first sampling edge; `kick_count` = 1.
- Immediately repeat 8'h55, 8'hAA (under 8 cycles after the kick) with window enabled -> `early_err` pulse, no `kick`, `kick_count` stays 1. Build without the macro -> `kick`, `kick_count` = 2.
- 8'h55 then 20 idle cycles (GAP_MAX = 16) -> `bad_key_err` when `gap_cnt` hits 16, then `armed` = 0. A subsequent 8'hAA alone -> `bad_key_err`.
- 8'h55, 8'h55, 8'hAA -> no error on the re-arm, exactly one `kick`.
- 8'h3C in IDLE -> `bad_key_err`. `ena` deasserted while ARMED -> `armed` = 0, a following 8'hAA strobe produces no pulse.
- 260 accepted kicks with MIN_PERIOD spacing -> `kick_count` saturates at 8'hFF. `rst` asserted mid-ARMED -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and defaults for the watchdog kick qualifier.
// Holds the FSM state type, default unlock keys and timing limits.
package wdt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } wdt_kick_state_e;

  localparam logic [7:0]  WDT_KEY0       = 8'h55;
  localparam logic [7:0]  WDT_KEY1       = 8'hAA;
  localparam int unsigned WDT_GAP_MAX    = 16;
  localparam int unsigned WDT_MIN_PERIOD = 8;

  // Increment that sticks at the given limit instead of wrapping.
  function automatic logic [7:0] wdt_inc_sat(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/wdt_kick_gate_if.sv
// Pin-side key inputs and watchdog-side pulse outputs of the kick qualifier.
// master drives the key pins and enable; slave is the qualifier itself.
interface wdt_kick_gate_if;
  logic       ena;
  logic       key_strobe;
  logic [7:0] key_in;
  logic       kick;
  logic       early_err;
  logic       bad_key_err;
  logic       armed;
  logic [7:0] kick_count;

  modport master (
    output ena, key_strobe, key_in,
    input  kick, early_err, bad_key_err, armed, kick_count
  );

  modport slave (
    input  ena, key_strobe, key_in,
    output kick, early_err, bad_key_err, armed, kick_count
  );
endinterface

// File: rtl/wdt_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous pin.
// ev_o is high for one cycle, two cycles after the first edge that samples d_i high.
module wdt_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic ev_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign ev_o = sync2_q & ~prev_q;

endmodule

// File: rtl/wdt_kick_gate.sv
// Qualifies KEY0/KEY1 unlock sequences from pins into single-cycle watchdog kicks or error pulses.
// Optional minimum kick spacing is compiled in with `define WDT_KICK_WINDOW_EN.
module wdt_kick_gate
  import wdt_pkg::*;
#(
  parameter logic [7:0]  KEY0       = WDT_KEY0,
  parameter logic [7:0]  KEY1       = WDT_KEY1,
  parameter int unsigned GAP_MAX    = WDT_GAP_MAX,
  parameter int unsigned MIN_PERIOD = WDT_MIN_PERIOD
) (
  input  logic                   clk,
  input  logic                   rst,
  wdt_kick_gate_if.slave         io
);

  localparam logic [7:0] GAP_LIM = 8'(GAP_MAX);

  logic            ev;
  wdt_kick_state_e state_q;
  logic [7:0]      gap_cnt_q;
  logic            kick_q;
  logic            bad_q;
  logic [7:0]      kick_count_q;
  logic            win_ok;

  // The synchronizer runs regardless of ena so an edge seen while disabled is already consumed.
  wdt_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_i  (io.key_strobe),
    .ev_o (ev)
  );

`ifdef WDT_KICK_WINDOW_EN
  localparam logic [7:0] MIN_LIM = 8'(MIN_PERIOD);

  logic       early_q;
  logic       seq_done;
  logic [7:0] since_kick_q;
  logic [7:0] since_kick_d;

  assign seq_done = io.ena && (state_q == ARMED) && ev && (io.key_in == KEY1);
  assign win_ok   = (since_kick_q >= MIN_LIM);

  // An early completion freezes the counter for that cycle instead of advancing it.
  always_comb begin
    since_kick_d = since_kick_q;
    if (io.ena) begin
      if (seq_done && win_ok) begin
        since_kick_d = 8'd0;
      end else if (!seq_done) begin
        since_kick_d = wdt_inc_sat(since_kick_q, MIN_LIM);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      since_kick_q <= MIN_LIM;
    end else begin
      since_kick_q <= since_kick_d;
    end
  end

  assign io.early_err = early_q;
`else
  assign win_ok       = 1'b1;
  assign io.early_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gap_cnt_q    <= 8'd0;
      kick_q       <= 1'b0;
      bad_q        <= 1'b0;
      kick_count_q <= 8'd0;
`ifdef WDT_KICK_WINDOW_EN
      early_q      <= 1'b0;
`endif
    end else begin
      kick_q <= 1'b0;
      bad_q  <= 1'b0;
`ifdef WDT_KICK_WINDOW_EN
      early_q <= 1'b0;
`endif
      if (!io.ena) begin
        state_q   <= IDLE;
        gap_cnt_q <= 8'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ev) begin
              if (io.key_in == KEY0) begin
                state_q   <= ARMED;
                gap_cnt_q <= 8'd0;
              end else begin
                bad_q <= 1'b1;
              end
            end
          end
          ARMED: begin
            // An event in the timeout cycle takes priority over the timeout.
            if (ev) begin
              if (io.key_in == KEY1) begin
                state_q <= IDLE;
                if (win_ok) begin
                  kick_q       <= 1'b1;
                  kick_count_q <= wdt_inc_sat(kick_count_q, 8'hFF);
                end
`ifdef WDT_KICK_WINDOW_EN
                else begin
                  early_q <= 1'b1;
                end
`endif
              end else if (io.key_in == KEY0) begin
                gap_cnt_q <= 8'd0;
              end else begin
                state_q <= IDLE;
                bad_q   <= 1'b1;
              end
            end else if ((gap_cnt_q + 8'd1) == GAP_LIM) begin
              state_q   <= IDLE;
              gap_cnt_q <= 8'd0;
              bad_q     <= 1'b1;
            end else begin
              gap_cnt_q <= gap_cnt_q + 8'd1;
            end
          end
          default: begin
            state_q   <= IDLE;
            gap_cnt_q <= 8'd0;
          end
        endcase
      end
    end
  end

  assign io.kick        = kick_q;
  assign io.bad_key_err = bad_q;
  assign io.armed       = (state_q == ARMED);
  assign io.kick_count  = kick_count_q;

endmodule

// File: tb/tb_wdt_kick_gate.sv
// Randomized scoreboard bench for wdt_kick_gate: a sequence-level model predicts each pulse and its cycle.
module tb_wdt_kick_gate;

  localparam int GAP  = 16;
  localparam int MINP = 8;
`ifdef WDT_KICK_WINDOW_EN
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wdt_kick_gate_if ifc ();

  wdt_kick_gate #(
    .KEY0       (8'h55),
    .KEY1       (8'hAA),
    .GAP_MAX    (GAP),
    .MIN_PERIOD (MINP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ena_low_edges = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!ifc.ena) ena_low_edges <= ena_low_edges + 1;
  end

  // kind: 0 kick, 1 early, 2 bad key; t: cycle count at which the pulse is visible
  typedef struct {
    int kind;
    int t;
    int cnt;
  } exp_t;
  exp_t q[$];

  bit m_armed, m_first, m_ena;
  int m_ta, m_cnt, m_tk, m_early, m_dis_k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int t, input int cnt);
    exp_t e;
    e.kind = kind;
    e.t    = t;
    e.cnt  = cnt;
    q.push_back(e);
  endfunction

  function automatic void m_reset();
    m_armed = 1'b0;
    m_first = 1'b1;
    m_cnt   = 0;
    m_tk    = 0;
    m_early = 0;
    m_dis_k = ena_low_edges;
  endfunction

  // Any armed sequence left waiting GAP cycles by time T has timed out.
  function automatic void m_advance(input int T);
    if (m_armed && (m_ta + GAP <= T)) begin
      push(2, m_ta + GAP, 0);
      m_armed = 1'b0;
    end
  endfunction

  function automatic void m_complete(input int t);
    int since;
    bit ok;
    since = (t - 1 - m_tk) - m_early - (ena_low_edges - m_dis_k);
    ok = !WIN || m_first || (since >= MINP);
    if (ok) begin
      m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
      push(0, t, m_cnt);
      m_first = 1'b0;
      m_tk    = t;
      m_early = 0;
      m_dis_k = ena_low_edges;
    end else begin
      push(1, t, 0);
      m_early++;
    end
  endfunction

  function automatic void m_event(input logic [7:0] b, input int t);
    if (!m_ena) return;
    m_advance(t - 1);
    if (!m_armed) begin
      if (b == 8'h55) begin
        m_armed = 1'b1;
        m_ta    = t;
      end else begin
        push(2, t, 0);
      end
    end else if (b == 8'hAA) begin
      m_armed = 1'b0;
      m_complete(t);
    end else if (b == 8'h55) begin
      m_ta = t;
    end else begin
      m_armed = 1'b0;
      push(2, t, 0);
    end
  endfunction

  task automatic wait_cycles(input int n);
    m_advance(cyc + n + 2);
    repeat (n) @(negedge clk);
  endtask

  // Strobe high for hi cycles, low for lo cycles; key held for the whole span (hi+lo >= 4, lo >= 2).
  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    ifc.key_in     = b;
    ifc.key_strobe = 1'b1;
    m_event(b, cyc + 3);
    wait_cycles(hi);
    ifc.key_strobe = 1'b0;
    wait_cycles(lo);
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a pulse; flags predicted pulses that never came.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [2:0] obs;
    if (!rst) begin
      while (q.size() > 0 && q[0].t < cyc) begin
        e = q.pop_front();
        chk($sformatf("missed_pulse_kind%0d", e.kind), cyc, e.t);
      end
      obs = {ifc.bad_key_err, ifc.early_err, ifc.kick};
      if (obs != 3'b000) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", obs, 3'b000);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", obs, 32'd1 << e.kind);
          chk("pulse_cycle", cyc, e.t);
          if (e.kind == 0) chk("kick_count_at_kick", ifc.kick_count, e.cnt);
        end
      end
    end
  end

  initial begin
    int         r, hi, lo;
    logic [7:0] b;
    rst            = 1'b1;
    ifc.ena        = 1'b1;
    ifc.key_strobe = 1'b0;
    ifc.key_in     = 8'h00;
    m_ena          = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_kick", ifc.kick, 0);
    chk("rst_early", ifc.early_err, 0);
    chk("rst_bad", ifc.bad_key_err, 0);
    chk("rst_armed", ifc.armed, 0);
    chk("rst_count", ifc.kick_count, 0);
    rst = 1'b0;
    wait_cycles(3);

    // basic unlock, then an immediate repeat inside the minimum window
    send_byte(8'h55, 2, 2);
    chk("armed_after_key0", ifc.armed, m_armed);
    send_byte(8'hAA, 2, 2);
    chk("count_after_first", ifc.kick_count, m_cnt);
    send_byte(8'h55, 2, 2);
    send_byte(8'hAA, 2, 2);
    wait_cycles(4);
    chk("count_after_repeat", ifc.kick_count, m_cnt);
    wait_cycles(12);

    // gap timeout, then a lone KEY1
    send_byte(8'h55, 2, 2);
    wait_cycles(20);
    chk("armed_after_timeout", ifc.armed, m_armed);
    send_byte(8'hAA, 2, 2);
    wait_cycles(12);

    // re-arm then complete, then a wrong byte in IDLE
    send_byte(8'h55, 2, 2);
    send_byte(8'h55, 2, 2);
    send_byte(8'hAA, 2, 2);
    wait_cycles(12);
    send_byte(8'h3C, 2, 2);

    // disable while armed; a KEY1 during disable must do nothing
    send_byte(8'h55, 2, 2);
    chk("armed_before_disable", ifc.armed, m_armed);
    ifc.ena = 1'b0;
    m_ena   = 1'b0;
    m_armed = 1'b0;
    wait_cycles(1);
    chk("armed_when_disabled", ifc.armed, 0);
    send_byte(8'hAA, 2, 2);
    wait_cycles(4);
    ifc.ena = 1'b1;
    m_ena   = 1'b1;
    wait_cycles(6);
    chk("armed_after_enable", ifc.armed, m_armed);

    // random byte stream with random spacing
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      b  = (r < 4) ? 8'h55 : (r < 8) ? 8'hAA : 8'($urandom_range(0, 255));
      hi = $urandom_range(1, 4);
      lo = ((hi >= 2) ? 2 : 4 - hi) +
           (($urandom_range(0, 3) == 0) ? $urandom_range(0, 24) : $urandom_range(0, 6));
      send_byte(b, hi, lo);
    end
    wait_cycles(20);

    // saturation of the kick counter
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h55, 2, 2);
      send_byte(8'hAA, 2, 3);
      wait_cycles(MINP);
    end
    chk("count_saturated", ifc.kick_count, m_cnt);
    chk("count_is_ff", ifc.kick_count, 8'hFF);

    // asynchronous reset in the middle of a sequence
    send_byte(8'h55, 2, 2);
    chk("armed_before_reset", ifc.armed, m_armed);
    #3 rst = 1'b1;
    #1;
    chk("midrst_kick", ifc.kick, 0);
    chk("midrst_bad", ifc.bad_key_err, 0);
    chk("midrst_early", ifc.early_err, 0);
    chk("midrst_armed", ifc.armed, 0);
    chk("midrst_count", ifc.kick_count, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(3);
    send_byte(8'h55, 2, 2);
    send_byte(8'hAA, 2, 2);
    wait_cycles(4);
    chk("count_after_reset_kick", ifc.kick_count, m_cnt);

    wait_cycles(30);
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
